bus_xfer_sequencer: RTL and testbench

//   Bus-master sequencer for the shared 16-bit tri-state DATA bus: accepts a reg-to-reg move

---
 rtl/bus_xfer_sequencer.sv | 125 ++++++++++++
 tb/tb_bus_xfer_sequencer.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_sequencer.sv
// Bus-master sequencer for the shared DATA bus: turns a reg-to-reg move request into
// one-hot drive (enable) and capture (latch) strobes with a settle window and a dead cycle.
module bus_xfer_sequencer #(
    parameter int NUM_REGS = 8,
    parameter int WIDTH    = 16,
    parameter int SETTLE   = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [2:0]          req_src,
    input  logic [2:0]          req_dst,
    output logic [NUM_REGS-1:0] enable,
    output logic [NUM_REGS-1:0] latch,
    input  logic [WIDTH-1:0]    DATA,
    output logic [WIDTH-1:0]    xfer_data,
    output logic                done,
    output logic                err
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2,
        GAP     = 2'd3
    } state_t;

    localparam logic [3:0]  SETTLE_INIT = 4'(SETTLE - 1);
    localparam logic [31:0] NUM_REGS_U  = NUM_REGS;

    state_t           state_reg, state_next;
    logic [3:0]       cnt_reg, cnt_next;
    logic [2:0]       src_reg, src_next;
    logic [2:0]       dst_reg, dst_next;
    logic             err_reg, err_next;
    logic [WIDTH-1:0] xfer_reg, xfer_next;

    logic req_illegal;
    logic drive_active;
    logic capture_active;

    // A request is rejected if either index is off the bus or it would move a register onto itself.
    assign req_illegal = ({29'd0, req_src} >= NUM_REGS_U) ||
                         ({29'd0, req_dst} >= NUM_REGS_U) ||
                         (req_src == req_dst);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            src_reg   <= '0;
            dst_reg   <= '0;
            err_reg   <= 1'b0;
            xfer_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            src_reg   <= src_next;
            dst_reg   <= dst_next;
            err_reg   <= err_next;
            xfer_reg  <= xfer_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        src_next   = src_reg;
        dst_next   = dst_reg;
        err_next   = err_reg;
        xfer_next  = xfer_reg;
        unique case (state_reg)
            IDLE: begin
                if (req_valid) begin
                    src_next = req_src;
                    dst_next = req_dst;
                    if (req_illegal) begin
                        err_next   = 1'b1;
                        state_next = GAP;
                    end else begin
                        err_next   = 1'b0;
                        cnt_next   = SETTLE_INIT;
                        state_next = DRIVE;
                    end
                end
            end
            DRIVE: begin
                if (cnt_reg == 4'd0) begin
                    state_next = CAPTURE;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            CAPTURE: begin
                // The destination latches on this same edge, so record what it saw.
                xfer_next  = DATA;
                state_next = GAP;
            end
            GAP: begin
                err_next   = 1'b0;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign drive_active   = (state_reg == DRIVE) || (state_reg == CAPTURE);
    assign capture_active = (state_reg == CAPTURE);

    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_strobe
            assign enable[gi] = drive_active   && (src_reg == 3'(gi));
            assign latch[gi]  = capture_active && (dst_reg == 3'(gi));
        end
    endgenerate

    assign req_ready = (state_reg == IDLE);
    assign done      = (state_reg == GAP);
    assign err       = (state_reg == GAP) && err_reg;
    assign xfer_data = xfer_reg;

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// Bench for bus_xfer_sequencer: table vectors, hand-written corner sequences and a
// randomized run against a per-transaction strobe-trace model, on SETTLE=1 and SETTLE=4 instances.
module tb_bus_xfer_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        rv;
    logic        sel;
    logic [2:0]  src, dst;
    logic [15:0] data;

    logic        rv1, rv4;
    logic        ready1, ready4, done1, done4, err1, err4;
    logic [7:0]  en1, en4, la1, la4;
    logic [15:0] xd1, xd4;

    logic        o_ready, o_done, o_err;
    logic [7:0]  o_en, o_la;
    logic [15:0] o_xd;

    int tests = 0;
    int fails = 0;
    logic [15:0] model_x1 = 16'h0;
    logic [15:0] model_x4 = 16'h0;

    always #5 clk = ~clk;

    assign rv1 = rv && !sel;
    assign rv4 = rv && sel;
    assign o_ready = sel ? ready4 : ready1;
    assign o_done  = sel ? done4  : done1;
    assign o_err   = sel ? err4   : err1;
    assign o_en    = sel ? en4    : en1;
    assign o_la    = sel ? la4    : la1;
    assign o_xd    = sel ? xd4    : xd1;

    bus_xfer_sequencer #(.NUM_REGS(8), .WIDTH(16), .SETTLE(1)) dut1 (
        .clk(clk), .reset(reset), .req_valid(rv1), .req_ready(ready1),
        .req_src(src), .req_dst(dst), .enable(en1), .latch(la1),
        .DATA(data), .xfer_data(xd1), .done(done1), .err(err1)
    );

    bus_xfer_sequencer #(.NUM_REGS(8), .WIDTH(16), .SETTLE(4)) dut4 (
        .clk(clk), .reset(reset), .req_valid(rv4), .req_ready(ready4),
        .req_src(src), .req_dst(dst), .enable(en4), .latch(la4),
        .DATA(data), .xfer_data(xd4), .done(done4), .err(err4)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_invariants();
        check("onehot0_enable", 32'($onehot0(o_en)), 32'd1);
        check("onehot0_latch", 32'($onehot0(o_la)), 32'd1);
        check("no_self_latch", 32'(o_en & o_la), 32'd0);
        check("latch_needs_enable", 32'((o_la != 8'h0) && (o_en == 8'h0)), 32'd0);
    endtask

    // Model: a legal move shows SETTLE+1 enable cycles, latch on the last of them, then one
    // done cycle; an illegal one shows only a done+err cycle. xfer_data takes DATA of the latch cycle.
    task automatic run_xfer(input logic which, input logic [2:0] s_i, input logic [2:0] d_i,
                            input logic fixed, input logic [15:0] fix_data,
                            output logic [7:0] en_seen, output logic [7:0] la_seen,
                            output logic err_seen, output logic [15:0] xd_seen);
        int st, len, w;
        logic legal;
        logic [7:0] one8, exp_en, exp_la;
        logic [15:0] exp_x;
        one8 = 8'h01;
        sel = which;
        st = which ? 4 : 1;
        legal = (s_i != d_i);
        en_seen = 8'h0;
        la_seen = 8'h0;
        err_seen = 1'b0;
        w = 0;
        while (!o_ready && w < 30) begin
            step();
            w++;
        end
        check("ready_before_req", 32'(o_ready), 32'd1);
        exp_x = which ? model_x4 : model_x1;
        src = s_i;
        dst = d_i;
        data = fixed ? fix_data : 16'($urandom);
        rv = 1'b1;
        step();
        rv = 1'b0;
        len = legal ? st + 2 : 1;
        for (int k = 1; k <= len; k++) begin
            exp_en = (legal && k <= st + 1) ? (one8 << s_i) : 8'h0;
            exp_la = (legal && k == st + 1) ? (one8 << d_i) : 8'h0;
            check("enable", 32'(o_en), 32'(exp_en));
            check("latch", 32'(o_la), 32'(exp_la));
            check("done", 32'(o_done), 32'(k == len));
            check("err", 32'(o_err), 32'((!legal) && (k == len)));
            check_invariants();
            en_seen |= o_en;
            la_seen |= o_la;
            if (k == len) err_seen = o_err;
            if (legal && k == st + 1) exp_x = data;
            step();
            if (!fixed) data = 16'($urandom);
        end
        check("ready_after_xfer", 32'(o_ready), 32'd1);
        check("idle_strobes", 32'({o_en, o_la}), 32'd0);
        check("xfer_data", 32'(o_xd), 32'(exp_x));
        xd_seen = o_xd;
        if (which) model_x4 = exp_x;
        else       model_x1 = exp_x;
    endtask

    typedef struct {
        logic        which;
        logic [2:0]  s;
        logic [2:0]  d;
        logic [15:0] dat;
        logic [7:0]  exp_en;
        logic [7:0]  exp_la;
        logic        exp_err;
        logic [15:0] exp_xd;
    } vec_t;

    vec_t tbl [7];

    initial begin
        logic [7:0]  en_s, la_s;
        logic        err_s;
        logic [15:0] xd_s;
        int first_b, done_cnt;
        logic zero_seen, bad_seen;

        tbl[0] = '{1'b0, 3'd2, 3'd5, 16'hA5C3, 8'h04, 8'h20, 1'b0, 16'hA5C3};
        tbl[1] = '{1'b1, 3'd0, 3'd7, 16'h1234, 8'h01, 8'h80, 1'b0, 16'h1234};
        tbl[2] = '{1'b0, 3'd3, 3'd3, 16'hDEAD, 8'h00, 8'h00, 1'b1, 16'hA5C3};
        tbl[3] = '{1'b0, 3'd7, 3'd0, 16'hFFFF, 8'h80, 8'h01, 1'b0, 16'hFFFF};
        tbl[4] = '{1'b1, 3'd1, 3'd1, 16'hBEEF, 8'h00, 8'h00, 1'b1, 16'h1234};
        tbl[5] = '{1'b1, 3'd6, 3'd4, 16'h0F0F, 8'h40, 8'h10, 1'b0, 16'h0F0F};
        tbl[6] = '{1'b0, 3'd0, 3'd1, 16'h8001, 8'h01, 8'h02, 1'b0, 16'h8001};

        reset = 1'b1;
        rv = 1'b0;
        sel = 1'b0;
        src = 3'd0;
        dst = 3'd0;
        data = 16'h0;
        repeat (3) step();
        reset = 1'b0;
        step();
        check("rst_ready1", 32'(ready1), 32'd1);
        check("rst_strobes1", 32'({en1, la1}), 32'd0);
        check("rst_done_err1", 32'({done1, err1}), 32'd0);
        check("rst_xfer1", 32'(xd1), 32'd0);
        check("rst_ready4", 32'(ready4), 32'd1);
        check("rst_xfer4", 32'(xd4), 32'd0);

        // Reset held for three cycles while the SETTLE=4 instance is in DRIVE.
        sel = 1'b1;
        src = 3'd0;
        dst = 3'd7;
        rv = 1'b1;
        step();
        rv = 1'b0;
        step();
        check("mid_drive_enable", 32'(en4), 32'h01);
        reset = 1'b1;
        step();
        check("reset_abort_strobes", 32'({en4, la4}), 32'd0);
        check("reset_abort_done", 32'(done4), 32'd0);
        step();
        check("reset_hold_done", 32'(done4), 32'd0);
        step();
        reset = 1'b0;
        step();
        check("post_reset_ready", 32'(ready4), 32'd1);
        check("post_reset_strobes", 32'({en4, la4}), 32'd0);
        check("post_reset_done", 32'(done4), 32'd0);
        model_x1 = 16'h0;
        model_x4 = 16'h0;

        for (int i = 0; i < 7; i++) begin
            run_xfer(tbl[i].which, tbl[i].s, tbl[i].d, 1'b1, tbl[i].dat, en_s, la_s, err_s, xd_s);
            check("tbl_enable", 32'(en_s), 32'(tbl[i].exp_en));
            check("tbl_latch", 32'(la_s), 32'(tbl[i].exp_la));
            check("tbl_err", 32'(err_s), 32'(tbl[i].exp_err));
            check("tbl_xfer", 32'(xd_s), 32'(tbl[i].exp_xd));
        end

        // Back-to-back: valid held, second request must wait for the dead cycle.
        sel = 1'b0;
        data = 16'h5A5A;
        src = 3'd1;
        dst = 3'd2;
        rv = 1'b1;
        step();
        src = 3'd4;
        dst = 3'd6;
        first_b = 0;
        zero_seen = 1'b0;
        done_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            if (first_b == 0 && en1 == 8'h10) first_b = k;
            if (first_b == 0 && en1 == 8'h0 && la1 == 8'h0) zero_seen = 1'b1;
            if (done1) done_cnt++;
            if (k == 5) rv = 1'b0;
            step();
        end
        check("b2b_second_start", 32'(first_b), 32'd5);
        check("b2b_dead_cycle", 32'(zero_seen), 32'd1);
        check("b2b_done_count", 32'(done_cnt), 32'd2);
        check("b2b_xfer", 32'(xd1), 32'h5A5A);
        model_x1 = 16'h5A5A;

        // Pulses on req_valid while busy are dropped, not queued.
        src = 3'd2;
        dst = 3'd3;
        rv = 1'b1;
        step();
        src = 3'd5;
        dst = 3'd6;
        done_cnt = 0;
        bad_seen = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if ((en1 & 8'h20) != 8'h0) bad_seen = 1'b1;
            if (done1) done_cnt++;
            if (k == 2) rv = 1'b0;
            step();
        end
        check("busy_pulse_ignored", 32'(bad_seen), 32'd0);
        check("busy_done_count", 32'(done_cnt), 32'd1);
        check("busy_final_idle", 32'({ready1, en1}), 32'h100);

        for (int i = 0; i < 1000; i++) begin
            logic w_i;
            logic [2:0] s_r, d_r;
            w_i = 1'($urandom_range(0, 1));
            s_r = 3'($urandom_range(0, 7));
            d_r = 3'($urandom_range(0, 7));
            repeat ($urandom_range(0, 2)) step();
            run_xfer(w_i, s_r, d_r, 1'b0, 16'h0, en_s, la_s, err_s, xd_s);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
